// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: loads a 14-bit binary value, converts it to four BCD digits
// with a sequential shift-add-3 converter, and multiplexes the digits onto a
// shared seven-segment bus with one-hot digit enables and leading-zero blanking.
module seg_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 1000,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [13:0] value,
    input  logic        load,
    output logic        ready,
    output logic        ovf,
    output logic [3:0]  digit_sel,
    output logic [6:0]  seg
);

    localparam int unsigned VW = 14;
    localparam int unsigned BW = 16;
    localparam int unsigned CW = 4;
    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [VW-1:0] MAX_VAL   = VW'(9999);
    localparam logic [CW-1:0] LAST_STEP = CW'(VW - 1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [VW-1:0]   bin_q;
    logic [BW-1:0]   bcd_q;
    logic [CW-1:0]   step_q;
    logic            ovf_q;
    logic [BW-1:0]   disp_q;

    logic [PW-1:0]   pre_q;
    logic [1:0]      idx_q;
    logic [3:0]      digit_sel_q;
    logic [6:0]      seg_q;

    logic [BW-1:0]   bcd_adj_c;
    logic [BW-1:0]   bcd_shift_c;
    logic [3:0]      cur_digit_c;
    logic            blank_c;
    logic [6:0]      pattern_c;
    logic            pre_wrap_c;

    assign ready     = (state_q == S_IDLE);
    assign ovf       = ovf_q;
    assign digit_sel = digit_sel_q;
    assign seg       = seg_q;

    // Add 3 to every BCD nibble >= 5, then shift in the next binary MSB
    always_comb begin
        bcd_adj_c = '0;
        for (int i = 0; i < 4; i++) begin
            bcd_adj_c[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? (bcd_q[i*4 +: 4] + 4'd3)
                                                            : bcd_q[i*4 +: 4];
        end
        bcd_shift_c = BW'({bcd_adj_c, bin_q[VW-1]});
    end

    // Converter FSM: IDLE accepts a load, CONV runs 14 steps, DONE publishes digits
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            step_q  <= '0;
            ovf_q   <= 1'b0;
            disp_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load) begin
                        bin_q   <= (value > MAX_VAL) ? MAX_VAL : value;
                        bcd_q   <= '0;
                        step_q  <= '0;
                        ovf_q   <= (value > MAX_VAL);
                        state_q <= S_CONV;
                    end
                end
                S_CONV: begin
                    bcd_q  <= bcd_shift_c;
                    bin_q  <= {bin_q[VW-2:0], 1'b0};
                    step_q <= step_q + CW'(1);
                    if (step_q == LAST_STEP) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    disp_q  <= bcd_q;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Digit currently selected and whether it is a leading zero to blank
    always_comb begin
        cur_digit_c = disp_q[{idx_q, 2'b00} +: 4];
        blank_c     = 1'b0;
        if (BLANK_LZ) begin
            case (idx_q)
                2'd1:    blank_c = (disp_q[15:4]  == 12'd0);
                2'd2:    blank_c = (disp_q[15:8]  == 8'd0);
                2'd3:    blank_c = (disp_q[15:12] == 4'd0);
                default: blank_c = 1'b0;
            endcase
        end
    end

    // Digit-to-segment decode, {g,f,e,d,c,b,a}
    always_comb begin
        pattern_c = 7'b0000000;
        case (cur_digit_c)
            4'd0:    pattern_c = 7'b0111111;
            4'd1:    pattern_c = 7'b0000110;
            4'd2:    pattern_c = 7'b1011011;
            4'd3:    pattern_c = 7'b1001111;
            4'd4:    pattern_c = 7'b1100110;
            4'd5:    pattern_c = 7'b1101101;
            4'd6:    pattern_c = 7'b1111101;
            4'd7:    pattern_c = 7'b0000111;
            4'd8:    pattern_c = 7'b1111111;
            4'd9:    pattern_c = 7'b1101111;
            default: pattern_c = 7'b0000000;
        endcase
    end

    assign pre_wrap_c = (pre_q == PRE_LAST);

    // Scan prescaler, digit index and registered display drive; en=0 freezes the scan
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q       <= '0;
            idx_q       <= '0;
            digit_sel_q <= '0;
            seg_q       <= '0;
        end else if (en) begin
            pre_q       <= pre_wrap_c ? '0 : (pre_q + PW'(1));
            if (pre_wrap_c) begin
                idx_q <= idx_q + 2'd1;
            end
            digit_sel_q <= 4'b0001 << idx_q;
            seg_q       <= blank_c ? 7'b0000000 : pattern_c;
        end else begin
            digit_sel_q <= '0;
            seg_q       <= '0;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed testbench for seg_scan_ctrl (REFRESH_DIV=4), with a second
// instance built without leading-zero blanking sharing the same stimulus.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        load = 1'b0;
    logic [13:0] value = '0;

    logic        ready, ovf;
    logic [3:0]  digit_sel;
    logic [6:0]  seg;
    logic        ready_nb, ovf_nb;
    logic [3:0]  digit_sel_nb;
    logic [6:0]  seg_nb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .value(value), .load(load),
        .ready(ready), .ovf(ovf), .digit_sel(digit_sel), .seg(seg)
    );

    seg_scan_ctrl #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .en(en), .value(value), .load(load),
        .ready(ready_nb), .ovf(ovf_nb), .digit_sel(digit_sel_nb), .seg(seg_nb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until digit k is selected (at least one edge); ok=0 if the bound expires
    task automatic find_digit(input int k, output bit ok);
        logic [3:0] want;
        want = 4'b0001 << k;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (digit_sel === want) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic start_load(input logic [13:0] v);
        value = v;
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
        checks++; if (ready_nb !== 1'b1) begin errors++; $display("FAIL reset_ready_nb got %b want 1", ready_nb); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
        checks++; if (digit_sel !== 4'b0000) begin errors++; $display("FAIL reset_sel got %b want 0000", digit_sel); end
        checks++; if (seg !== 7'b0000000) begin errors++; $display("FAIL reset_seg got %b want 0000000", seg); end
        rst = 1'b0;
        tick();
        checks++; if (digit_sel !== 4'b0001) begin errors++; $display("FAIL post_reset_sel got %b want 0001", digit_sel); end
        checks++; if (seg !== 7'b0111111) begin errors++; $display("FAIL post_reset_seg got %b want 0111111", seg); end
    endtask

    task automatic test_conv_1234();
        int n;
        int cnt;
        bit ok;
        logic [6:0] exp [4];
        exp[0] = 7'b1100110; exp[1] = 7'b1001111; exp[2] = 7'b1011011; exp[3] = 7'b0000110;
        start_load(14'd1234);
        wait_ready(n);
        checks++; if (n != 15) begin errors++; $display("FAIL conv_busy_cycles got %0d want 15", n); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL conv_ovf got %b want 0", ovf); end
        for (int k = 0; k < 4; k++) begin
            find_digit(k, ok);
            checks++;
            if (!ok || seg !== exp[k]) begin
                errors++; $display("FAIL conv_1234_digit%0d found=%0b seg got %b want %b", k, ok, seg, exp[k]);
            end
        end
        find_digit(0, ok);
        find_digit(1, ok);
        cnt = 0;
        do begin
            cnt++;
            tick();
        end while (digit_sel === 4'b0010 && cnt < 20);
        checks++; if (!ok || cnt != 4) begin errors++; $display("FAIL dwell found=%0b got %0d want 4", ok, cnt); end
        checks++; if (digit_sel !== 4'b0100) begin errors++; $display("FAIL scan_order got %b want 0100", digit_sel); end
    endtask

    task automatic test_blank();
        int n;
        bit ok;
        logic [6:0] exp_b [4];
        logic [6:0] exp_nb [4];
        exp_b[0]  = 7'b0000111; exp_b[1]  = 7'b0000000; exp_b[2]  = 7'b0000000; exp_b[3]  = 7'b0000000;
        exp_nb[0] = 7'b0000111; exp_nb[1] = 7'b0111111; exp_nb[2] = 7'b0111111; exp_nb[3] = 7'b0111111;
        start_load(14'd7);
        wait_ready(n);
        checks++; if (n != 15) begin errors++; $display("FAIL blank_busy_cycles got %0d want 15", n); end
        for (int k = 0; k < 4; k++) begin
            find_digit(k, ok);
            checks++;
            if (!ok || seg !== exp_b[k]) begin
                errors++; $display("FAIL blank_lz_digit%0d found=%0b seg got %b want %b", k, ok, seg, exp_b[k]);
            end
            checks++;
            if (digit_sel_nb !== digit_sel || seg_nb !== exp_nb[k]) begin
                errors++; $display("FAIL no_blank_digit%0d sel got %b seg got %b want %b", k, digit_sel_nb, seg_nb, exp_nb[k]);
            end
        end
    endtask

    task automatic test_ovf();
        int n;
        bit ok;
        start_load(14'd12000);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", ovf); end
        checks++; if (ovf_nb !== 1'b1) begin errors++; $display("FAIL ovf_set_nb got %b want 1", ovf_nb); end
        wait_ready(n);
        for (int k = 0; k < 4; k++) begin
            find_digit(k, ok);
            checks++;
            if (!ok || seg !== 7'b1101111) begin
                errors++; $display("FAIL ovf_clamp_digit%0d found=%0b seg got %b want 1101111", k, ok, seg);
            end
        end
        start_load(14'd5);
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", ovf); end
        wait_ready(n);
        find_digit(0, ok);
        checks++; if (!ok || seg !== 7'b1101101) begin errors++; $display("FAIL five_digit0 found=%0b seg got %b want 1101101", ok, seg); end
        find_digit(1, ok);
        checks++; if (!ok || seg !== 7'b0000000) begin errors++; $display("FAIL five_digit1 found=%0b seg got %b want 0000000", ok, seg); end
    endtask

    task automatic test_back_to_back();
        int n;
        bit ok;
        logic [6:0] exp [4];
        exp[0] = 7'b1011011; exp[1] = 7'b1100110; exp[2] = 7'b0000000; exp[3] = 7'b0000000;
        value = 14'd42;
        load  = 1'b1;
        tick();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (ready === 1'b1) break;
            value = (i == 0) ? 14'd16383 : 14'(100 + i * 37);
            tick();
            n++;
        end
        load = 1'b0;
        checks++; if (n != 15) begin errors++; $display("FAIL b2b_busy_cycles got %0d want 15", n); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf got %b want 0", ovf); end
        tick();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_stays got %b want 1", ready); end
        for (int k = 0; k < 4; k++) begin
            find_digit(k, ok);
            checks++;
            if (!ok || seg !== exp[k]) begin
                errors++; $display("FAIL b2b_digit%0d found=%0b seg got %b want %b", k, ok, seg, exp[k]);
            end
        end
    endtask

    task automatic test_enable();
        bit ok;
        int cnt;
        find_digit(0, ok);
        find_digit(1, ok);
        tick();
        checks++; if (!ok || digit_sel !== 4'b0010) begin errors++; $display("FAIL en_setup found=%0b sel got %b want 0010", ok, digit_sel); end
        en = 1'b0;
        tick();
        checks++; if (digit_sel !== 4'b0000 || seg !== 7'b0000000) begin
            errors++; $display("FAIL en_off_first sel got %b seg got %b want 0000/0000000", digit_sel, seg);
        end
        repeat (9) tick();
        checks++; if (digit_sel !== 4'b0000 || seg !== 7'b0000000) begin
            errors++; $display("FAIL en_off_last sel got %b seg got %b want 0000/0000000", digit_sel, seg);
        end
        en = 1'b1;
        tick();
        checks++; if (digit_sel !== 4'b0010 || seg !== 7'b1100110) begin
            errors++; $display("FAIL en_resume sel got %b seg got %b want 0010/1100110", digit_sel, seg);
        end
        cnt = 0;
        while (digit_sel === 4'b0010 && cnt < 20) begin
            cnt++;
            tick();
        end
        checks++; if (cnt != 2) begin errors++; $display("FAIL en_resume_dwell got %0d want 2", cnt); end
        checks++; if (digit_sel !== 4'b0100) begin errors++; $display("FAIL en_resume_next got %b want 0100", digit_sel); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        start_load(14'd9999);
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (ready !== 1'b1 || ovf !== 1'b0) begin
            errors++; $display("FAIL midrst_ctrl ready got %b ovf got %b want 1/0", ready, ovf);
        end
        checks++; if (digit_sel !== 4'b0000 || seg !== 7'b0000000) begin
            errors++; $display("FAIL midrst_out sel got %b seg got %b want 0000/0000000", digit_sel, seg);
        end
        tick();
        checks++; if (digit_sel !== 4'b0001 || seg !== 7'b0111111) begin
            errors++; $display("FAIL midrst_zero sel got %b seg got %b want 0001/0111111", digit_sel, seg);
        end
        repeat (20) tick();
        find_digit(0, ok);
        checks++; if (!ok || seg !== 7'b0111111) begin errors++; $display("FAIL midrst_late_d0 found=%0b seg got %b want 0111111", ok, seg); end
        find_digit(3, ok);
        checks++; if (!ok || seg !== 7'b0000000) begin errors++; $display("FAIL midrst_late_d3 found=%0b seg got %b want 0000000", ok, seg); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_conv_1234();
        test_blank();
        test_ovf();
        test_back_to_back();
        test_enable();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Sequencing controller for the four-digit multiplexed seven-segment display. It accepts a 14-bit binary value through a ready/load handshake and converts it sequentially (shift-add-3) into four BCD digits. It then time-multiplexes those digits onto a shared segment bus with one-hot digit enables, and applies the team's digit-to-segment patterns internally. It sits between the game/score logic and the board's display pins.

## Interface
- REFRESH_DIV, 1000: clock cycles each digit stays selected; legal range ≥2.
- BLANK_LZ, 1: 1 = blank leading zeros (digit 0 never blanked); 0 = show all four digits.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  display enable; 0 forces digit_sel=0, seg=0 and freezes scan position.
- value  input  14  binary value to display; sampled only on an accepted load.
- load  input  1  request to convert and display value.
- ready  output  1  high when a load will be accepted (converter idle).
- ovf  output  1  high when the last accepted value exceeded 9999.
- digit_sel  output  4  one-hot digit enable, bit 0 = least-significant digit, active-high.
- seg  output  7  segment drive {g,f,e,d,c,b,a}, active-high.

## Operation
- Converter FSM states are IDLE, CONV and DONE. ready = (state==IDLE), combinational from state.
- IDLE: if load=1, latch min(value, 9999) into the shift register and clear the BCD accumulator. Set ovf = (value > 9999). Go to CONV.
- CONV: exactly 14 cycles. Each cycle, add 3 to every BCD nibble ≥5, then shift left one bit from the binary register. Then go to DONE.
- DONE: copy the four BCD nibbles into the display registers d0..d3, then return to IDLE.
- load while ready=0 is ignored: no queuing, no effect on the conversion in progress or on ovf.
- Display registers change only in DONE, so the scan never shows a partially converted value.
- Scan: a prescaler counts 0..REFRESH_DIV-1. When it wraps, digit index advances 0→1→2→3→0.
- Registered outputs each cycle when en=1:
  - digit_sel = one-hot(index).
  - seg = pattern(d[index]), or 0 if that digit is blanked.
- Blanking, when BLANK_LZ=1: digit k (k≥1) is blanked when d[k] and all higher digits are 0. Blanked digits keep digit_sel asserted and drive seg=0.
- Segment patterns:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - any other nibble = 0000000
- en=0: prescaler and index hold their values, digit_sel=0 and seg=0 from the next cycle. The converter is unaffected by en.

## Timing
- Reset values:
  - state=IDLE, so ready=1 during and after reset.
  - ovf=0, d0..d3=0.
  - prescaler=0, index=0, digit_sel=0000, seg=0000000.
- First cycle after rst deasserts with en=1: digit_sel=0001, seg=0111111 (shows "0").
- Load accepted at edge T (ready=1, load=1):
  - state=CONV from T+1 through T+14, DONE at T+15, IDLE at T+16.
  - ready is low for 15 cycles; a load at edge T+16 is accepted.
  - ovf updates at T+1.
- Display registers hold the new value after edge T+16. seg reflects it from the following registered update.
- digit_sel dwell: each one-hot value persists exactly REFRESH_DIV cycles. Full frame = 4·REFRESH_DIV cycles.
- rst asserted mid-conversion: abort to IDLE and clear the display to the reset state on that edge. The pending value is discarded.
- load and rst in the same cycle: rst wins.
- Simultaneous DONE write and scan advance: the newly selected digit shows the new value.

## Test plan
- Reset → ready=1, ovf=0, digit_sel=0000, seg=0. One cycle after release with en=1 → digit_sel=0001, seg=0111111.
- load value=1234, REFRESH_DIV=4 → ready low 15 cycles. Scan then cycles digit_sel 0001/0010/0100/1000 every 4 cycles, with seg = 1100110/1001111/1011011/0000110 respectively.
- load value=7 with BLANK_LZ=1 → digit 0 shows 0000111, digits 1–3 show seg=0. With BLANK_LZ=0 → digits 1–3 show 0111111.
- load value=12000 → ovf=1, display shows 9999 (1101111 on all digits). Next load of 5 → ovf=0.
- load asserted every cycle during a conversion of 42 with a different value → ignored. Display shows 42 and ready returns high at T+16.
- rst pulsed at T+7 of a conversion of 9999 → display stays "0", ready=1 next cycle. en=0 for 10 cycles → outputs 0 and scan resumes at the same digit and prescaler count.
